// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared types and defaults for mem_bus_arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int DEF_AW        = 32;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LD  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_LD  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/arb_port_ret.sv
// ---------------------------------------------------------------------------
// arb_port_ret : per-requester read-return register (rdata capture, rvalid).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_port_ret
  import mem_arb_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          cap_i,
  input  logic [DW-1:0] bus_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o
);

  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q;

  always_comb begin
    rdata_d = rdata_q;
    if (cap_i) rdata_d = bus_i;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= cap_i;
    end
  end

  // A reset landing on the return cycle swallows the pulse.
  assign rvalid_o = rvalid_q & ~rst;
  assign rdata_o  = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter : round-robin, burst-bounded CPU / loader memory arbiter.
// Optional grant counters with ARB_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_rvalid,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] Mem_Bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   cpu_grant_cnt,
  output logic [31:0]   ld_grant_cnt
`endif
);

  localparam int            BW         = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  owner_e        last_owner_q, last_owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && ld_req)
          state_d = (last_owner_q == OWNER_CPU) ? OWN_LD : OWN_CPU;
        else if (cpu_req) state_d = OWN_CPU;
        else if (ld_req)  state_d = OWN_LD;
      end
      OWN_CPU: begin
        if (!cpu_req)                              state_d = ld_req ? OWN_LD : IDLE;
        else if (ld_req && burst_cnt_q == BURST_LAST) state_d = OWN_LD;
      end
      OWN_LD: begin
        if (!ld_req)                                state_d = cpu_req ? OWN_CPU : IDLE;
        else if (cpu_req && burst_cnt_q == BURST_LAST) state_d = OWN_CPU;
      end
      default: state_d = IDLE;
    endcase
    // Saturate so a long solo run still yields promptly once the other side asks.
    if (state_d == state_q && state_q != IDLE)
      burst_cnt_d = (burst_cnt_q == BURST_LAST) ? burst_cnt_q : burst_cnt_q + 1'b1;
    if (state_d != state_q && state_d == OWN_CPU) last_owner_d = OWNER_CPU;
    if (state_d != state_q && state_d == OWN_LD)  last_owner_d = OWNER_LD;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_CPU;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign cpu_gnt  = (state_q == OWN_CPU) & cpu_req & ~rst;
  assign ld_gnt   = (state_q == OWN_LD)  & ld_req  & ~rst;
  assign mem_cs   = cpu_gnt | ld_gnt;
  assign mem_we   = (cpu_gnt & cpu_we) | (ld_gnt & ld_we);
  assign mem_addr = cpu_gnt ? cpu_addr : (ld_gnt ? ld_addr : '0);
  assign Mem_Bus  = mem_we ? (cpu_gnt ? cpu_wdata : ld_wdata) : 'z;

  arb_port_ret #(.DW(DW)) u_ret_cpu (
    .CLK      (CLK),
    .rst      (rst),
    .cap_i    (cpu_gnt & ~cpu_we),
    .bus_i    (Mem_Bus),
    .rdata_o  (cpu_rdata),
    .rvalid_o (cpu_rvalid)
  );

  arb_port_ret #(.DW(DW)) u_ret_ld (
    .CLK      (CLK),
    .rst      (rst),
    .cap_i    (ld_gnt & ~ld_we),
    .bus_i    (Mem_Bus),
    .rdata_o  (ld_rdata),
    .rvalid_o (ld_rvalid)
  );

`ifdef ARB_STATS_EN
  logic [31:0] cpu_cnt_q, cpu_cnt_d, ld_cnt_q, ld_cnt_d;

  always_comb begin
    cpu_cnt_d = cpu_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    if (cpu_gnt && cpu_cnt_q != 32'hFFFF_FFFF) cpu_cnt_d = cpu_cnt_q + 32'd1;
    if (ld_gnt  && ld_cnt_q  != 32'hFFFF_FFFF) ld_cnt_d  = ld_cnt_q  + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      cpu_cnt_q <= '0;
      ld_cnt_q  <= '0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
    end
  end

  assign cpu_grant_cnt = cpu_cnt_q;
  assign ld_grant_cnt  = ld_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter : directed vector table plus randomized run against a
// rule-level arbitration model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;
  localparam logic [31:0] L0 = 32'h2001_0006;

  logic          CLK = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, ld_req, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata;
  logic          cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid;
  logic [DW-1:0] cpu_rdata, ld_rdata;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] Mem_Bus;
`ifdef ARB_STATS_EN
  logic [31:0]   cpu_grant_cnt, ld_grant_cnt;
`endif

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .Mem_Bus(Mem_Bus)
`ifdef ARB_STATS_EN
    , .cpu_grant_cnt(cpu_grant_cnt), .ld_grant_cnt(ld_grant_cnt)
`endif
  );

  // Behavioural memory: combinational read onto the bus, write on the clock edge.
  logic [31:0] mem [0:255];
  logic        load;
  assign Mem_Bus = (mem_cs && !mem_we) ? mem[mem_addr[7:0]] : 'z;
  always @(posedge CLK) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_0000 | i;
      mem[8] <= 32'h0041_2022;
    end else if (mem_cs && mem_we) begin
      mem[mem_addr[7:0]] <= Mem_Bus;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        lreq, lwe;
    logic [31:0] laddr, lwd;
    logic        e_cg, e_lg, e_cs, e_we;
    logic [31:0] e_addr;
    logic        e_crv, e_lrv;
    logic [31:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic r, cq, cw, input logic [31:0] ca, cd,
                              input logic lq, lw, input logic [31:0] la, ldd,
                              input logic gc, gl, cs, we, input logic [31:0] ea,
                              input logic rc, rl, input logic [31:0] rd);
    vec_t v;
    v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
    v.lreq = lq; v.lwe = lw; v.laddr = la; v.lwd = ldd;
    v.e_cg = gc; v.e_lg = gl; v.e_cs = cs; v.e_we = we; v.e_addr = ea;
    v.e_crv = rc; v.e_lrv = rl; v.e_rd = rd;
    return v;
  endfunction

  vec_t vt [20];

  // Rule-level model state: owner 0=none 1=cpu 2=loader; last 0=cpu 1=loader.
  int          m_own, m_last, m_run, m_pv, nxt, other;
  logic [31:0] m_pd;
  logic        eg_c, eg_l, e_cs, e_we, e_crv, e_lrv, pg_c, pg_l, mine, oth;
  logic [31:0] e_addr;

  initial begin
    vt[0]  = mk(1, 1,0,8,0,              1,1,0,L0,    0,0,0,0,0,  0,0,0);
    vt[1]  = mk(1, 1,0,8,0,              1,1,0,L0,    0,0,0,0,0,  0,0,0);
    vt[2]  = mk(0, 1,0,8,0,              1,1,0,L0,    0,0,0,0,0,  0,0,0);
    vt[3]  = mk(0, 1,0,8,0,              1,1,0,L0,    0,1,1,1,0,  0,0,0);
    vt[4]  = mk(0, 1,0,8,0,              1,1,1,L0+1,  0,1,1,1,1,  0,0,0);
    vt[5]  = mk(0, 1,0,8,0,              1,1,2,L0+2,  0,1,1,1,2,  0,0,0);
    vt[6]  = mk(0, 1,0,8,0,              1,1,3,L0+3,  0,1,1,1,3,  0,0,0);
    vt[7]  = mk(0, 1,0,8,0,              1,1,4,L0+4,  1,0,1,0,8,  0,0,0);
    vt[8]  = mk(0, 1,1,16,32'h1111_1111, 1,1,4,L0+4,  1,0,1,1,16, 1,0,32'h0041_2022);
    vt[9]  = mk(0, 1,1,17,32'h2222_2222, 1,1,4,L0+4,  1,0,1,1,17, 0,0,0);
    vt[10] = mk(0, 1,0,0,0,              1,1,4,L0+4,  1,0,1,0,0,  0,0,0);
    vt[11] = mk(0, 0,0,0,0,              1,1,4,L0+4,  0,1,1,1,4,  1,0,L0);
    vt[12] = mk(0, 0,0,0,0,              1,0,16,0,    0,1,1,0,16, 0,0,0);
    vt[13] = mk(1, 0,0,0,0,              1,1,5,L0+5,  0,0,0,0,0,  0,0,0);
    vt[14] = mk(0, 0,0,0,0,              1,1,5,L0+5,  0,0,0,0,0,  0,0,0);
    vt[15] = mk(0, 0,0,0,0,              1,1,5,L0+5,  0,1,1,1,5,  0,0,0);
    vt[16] = mk(0, 0,0,0,0,              0,0,0,0,     0,0,0,0,0,  0,0,0);
    vt[17] = mk(0, 1,0,5,0,              0,0,0,0,     0,0,0,0,0,  0,0,0);
    vt[18] = mk(0, 1,0,5,0,              0,0,0,0,     1,0,1,0,5,  0,0,0);
    vt[19] = mk(0, 0,0,0,0,              0,0,0,0,     0,0,0,0,0,  1,0,L0+5);

    rst = 1'b1; load = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req  = 0; ld_we  = 0; ld_addr  = '0; ld_wdata  = '0;
    @(negedge CLK);
    load = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      rst = vt[i].rst;
      cpu_req = vt[i].creq; cpu_we = vt[i].cwe; cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwd;
      ld_req  = vt[i].lreq; ld_we  = vt[i].lwe; ld_addr  = vt[i].laddr; ld_wdata  = vt[i].lwd;
      #1;
      chk($sformatf("v%0d cpu_gnt", i),    32'(cpu_gnt),    32'(vt[i].e_cg));
      chk($sformatf("v%0d ld_gnt", i),     32'(ld_gnt),     32'(vt[i].e_lg));
      chk($sformatf("v%0d mem_cs", i),     32'(mem_cs),     32'(vt[i].e_cs));
      chk($sformatf("v%0d mem_we", i),     32'(mem_we),     32'(vt[i].e_we));
      chk($sformatf("v%0d mem_addr", i),   mem_addr,        vt[i].e_addr);
      chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vt[i].e_crv));
      chk($sformatf("v%0d ld_rvalid", i),  32'(ld_rvalid),  32'(vt[i].e_lrv));
      if (vt[i].e_we)
        chk($sformatf("v%0d Mem_Bus", i), Mem_Bus, vt[i].e_lg ? vt[i].lwd : vt[i].cwd);
      if (vt[i].e_crv) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vt[i].e_rd);
      if (vt[i].e_lrv) chk($sformatf("v%0d ld_rdata", i),  ld_rdata,  vt[i].e_rd);
`ifdef ARB_STATS_EN
      if (i == 14) begin
        chk("cpu_grant_cnt after rst", cpu_grant_cnt, 32'd0);
        chk("ld_grant_cnt after rst",  ld_grant_cnt,  32'd0);
      end
`endif
    end

    // Randomized phase with a fresh reset.
    @(negedge CLK);
    rst = 1'b1; cpu_req = 0; ld_req = 0;
    @(negedge CLK);
    m_own = 0; m_last = 0; m_run = 0; m_pv = -1; m_pd = '0; pg_c = 0; pg_l = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      rst = ($urandom_range(0, 199) == 0);
      if (!cpu_req || pg_c) begin
        cpu_req = ($urandom_range(0, 99) < 65); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = $urandom_range(0, 31); cpu_wdata = $urandom;
      end
      if (!ld_req || pg_l) begin
        ld_req = ($urandom_range(0, 99) < 65); ld_we = 1'($urandom_range(0, 1));
        ld_addr = $urandom_range(0, 31); ld_wdata = $urandom;
      end
      #1;
      eg_c   = !rst && m_own == 1 && cpu_req;
      eg_l   = !rst && m_own == 2 && ld_req;
      e_cs   = eg_c || eg_l;
      e_we   = eg_c ? cpu_we : (eg_l ? ld_we : 1'b0);
      e_addr = eg_c ? cpu_addr : (eg_l ? ld_addr : 32'd0);
      e_crv  = !rst && m_pv == 0;
      e_lrv  = !rst && m_pv == 1;
      chk($sformatf("r%0d cpu_gnt", cyc),    32'(cpu_gnt),    32'(eg_c));
      chk($sformatf("r%0d ld_gnt", cyc),     32'(ld_gnt),     32'(eg_l));
      chk($sformatf("r%0d mem_cs", cyc),     32'(mem_cs),     32'(e_cs));
      chk($sformatf("r%0d mem_we", cyc),     32'(mem_we),     32'(e_we));
      chk($sformatf("r%0d mem_addr", cyc),   mem_addr,        e_addr);
      chk($sformatf("r%0d cpu_rvalid", cyc), 32'(cpu_rvalid), 32'(e_crv));
      chk($sformatf("r%0d ld_rvalid", cyc),  32'(ld_rvalid),  32'(e_lrv));
      if (e_we)  chk($sformatf("r%0d Mem_Bus", cyc), Mem_Bus, eg_c ? cpu_wdata : ld_wdata);
      if (e_crv) chk($sformatf("r%0d cpu_rdata", cyc), cpu_rdata, m_pd);
      if (e_lrv) chk($sformatf("r%0d ld_rdata", cyc),  ld_rdata,  m_pd);

      if (rst) begin
        m_own = 0; m_last = 0; m_run = 0; m_pv = -1;
      end else begin
        m_pv = -1;
        if (e_cs && !e_we) begin
          m_pv = eg_c ? 0 : 1;
          m_pd = mem[e_addr[7:0]];
        end
        if (m_own == 0) begin
          if (cpu_req && ld_req) nxt = (m_last == 0) ? 2 : 1;
          else if (cpu_req)      nxt = 1;
          else if (ld_req)       nxt = 2;
          else                   nxt = 0;
        end else begin
          mine  = (m_own == 1) ? cpu_req : ld_req;
          oth   = (m_own == 1) ? ld_req  : cpu_req;
          other = 3 - m_own;
          if (!mine)                          nxt = oth ? other : 0;
          else if (oth && m_run >= MAX_BURST - 1) nxt = other;
          else                                nxt = m_own;
        end
        if (nxt == m_own && nxt != 0) m_run++;
        else                          m_run = 0;
        if (nxt != 0 && nxt != m_own) m_last = nxt - 1;
        m_own = nxt;
      end
      pg_c = eg_c;
      pg_l = eg_l;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single `Memory` port (CS, WE, Address, bidirectional data bus) between two requesters:
  - the MIPS core (port CPU);
  - a program loader/DMA engine (port LD), which replaces the ad-hoc init mux.
- Uses registered ownership with round-robin tie-break and a bounded burst length.
- Steers write data onto the memory bus and returns read data to the owning requester with a valid pulse.
- Sits between `MIPS`, the loader and `Memory` at the top level.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_BURST, 4, max consecutive granted cycles while the other requester waits (≥1)

Ports:
- CLK  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, level, held until granted
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU owns bus this cycle; access performed this cycle
- cpu_rdata  out  DW  read data
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- ld_req / ld_we / ld_addr / ld_wdata / ld_gnt / ld_rdata / ld_rvalid  same as CPU set, loader side
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- Mem_Bus  inout  DW  memory data bus
- cpu_grant_cnt  out  32  only with ARB_STATS_EN
- ld_grant_cnt  out  32  only with ARB_STATS_EN

Behaviour:
- Interface: one clock `CLK`; reset `rst` is synchronous and active-high.
- FSM states:
  - IDLE, OWN_CPU, OWN_LD.
  - Registered: `last_owner` (1b), `burst_cnt` (log2 MAX_BURST+1 bits), `rd_pend`, `rd_owner`.
- Reset:
  - state=IDLE, last_owner=CPU (so LD wins the first tie), burst_cnt=0, rd_pend=0.
  - All gnt/rvalid/mem_cs/mem_we=0, mem_addr=0, rdata=0, Mem_Bus=Z.
- IDLE transitions:
  - Only one req → OWN_that one.
  - Both reqs → OWN of the requester ≠ last_owner.
  - None → stay IDLE.
- OWN_X transitions:
  - req_X=0 → OWN_other if the other requests, else IDLE.
  - req_X=1, other requesting, and burst_cnt==MAX_BURST-1 → OWN_other (forced yield).
  - Otherwise stay, burst_cnt++.
  - burst_cnt clears on every ownership change; last_owner updates on entry to OWN_X.
- Grant latency: a request seen in IDLE is granted on the next cycle (1-cycle latency).
  - gnt_X = (state==OWN_X) & req_X, derived combinationally from registered state.
  - A requester holding req in OWN_X gets a grant every cycle (back-to-back).
- Memory side:
  - mem_cs = any gnt; mem_we/mem_addr = owner's we/addr when granted, else 0.
  - Mem_Bus is driven with owner's wdata only when mem_we=1, else Z.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=X.
  - Next cycle, rdata_X is captured from Mem_Bus and rvalid_X pulses for 1 cycle.
  - Read latency: 1 cycle after the gnt cycle.
  - rdata_X holds its value until the next read for X.
- Simultaneous events:
  - An ownership switch in the same cycle as a read return still routes the data to rd_owner.
  - A write never produces rvalid.
- Reset mid-burst: the next cycle returns to IDLE and any pending rvalid is suppressed.
- Requester obligations: keep addr/we/wdata stable while req=1 until the cycle it is granted. Changing them after grant affects only later accesses.

Optional Feature:
- ARB_STATS_EN
  - Defined: cpu_grant_cnt/ld_grant_cnt increment on each cycle gnt_X=1, saturate at 0xFFFFFFFF, clear on rst.
  - Undefined: the ports and counters do not exist.

Decomposition:
- Package mem_arb_pkg:
  - owner encoding (OWN_CPU=0, OWN_LD=1);
  - state enum (IDLE, OWN_CPU, OWN_LD);
  - default AW/DW/MAX_BURST constants.
- Sub-module arb_port_ret: per-requester read-return register (rdata capture + rvalid pulse), instantiated twice.
- FSM and bus steering stay in the top module.

Test Plan:
- rst=1 for 2 cycles with both reqs high → all gnt=0, mem_cs=0, Mem_Bus=Z. First cycle after rst falls: ld_gnt=1, cpu_gnt=0.
- LD alone writes addr 0..3 with data 0x20010006.. → ld_gnt 1 cycle after req, mem_we=1 for 4 consecutive cycles, Mem_Bus carries each word.
- CPU read addr 8 (memory holds 0x00412022) → cpu_gnt next cycle, cpu_rvalid 1 cycle later with cpu_rdata=0x00412022, ld_rvalid stays 0.
- Both requesters hold req continuously, MAX_BURST=4 → grants alternate in runs of 4 (LD×4, CPU×4, …), no idle cycles.
- CPU read granted, then CPU drops req as LD writes → ownership switches; cpu_rvalid still pulses with correct data, and the LD write is not disturbed.
- rst asserted on the 2nd cycle of an LD burst, with a read pending → next cycle IDLE, no rvalid. With ARB_STATS_EN, counters read 0.
